// File: rtl/rv_width_packer.sv
// rv_width_packer
// ---------------------------------------------------------------------------
// Ready/valid width up-converter. Packs RATIO consecutive IN_WIDTH-bit beats
// little-endian (first beat in the LSBs) into one IN_WIDTH*RATIO-bit word.
// The output word is fully registered. An input last flag flushes a partial
// word early, together with a count of how many of its lanes hold beats.
//
// Ports
//   clock_port         in   rising-edge clock
//   reset_port         in   synchronous, active-high reset
//   input_port_data    in   IN_WIDTH input beat
//   input_port_last    in   beat ends its packet (qualified by valid)
//   input_port_valid   in   input beat present
//   input_port_ready   out  beat accepted this cycle (no valid->ready path)
//   output_port_data   out  IN_WIDTH*RATIO packed word
//   output_port_count  out  number of valid beats in the word (1..RATIO)
//   output_port_last   out  word ends a packet
//   output_port_valid  out  word present
//   output_port_ready  in   downstream accepts the word
// ---------------------------------------------------------------------------
module rv_width_packer #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 4
) (
   input  logic                          clock_port,
   input  logic                          reset_port,
   input  logic [IN_WIDTH-1:0]           input_port_data,
   input  logic                          input_port_last,
   input  logic                          input_port_valid,
   output logic                          input_port_ready,
   output logic [IN_WIDTH*RATIO-1:0]     output_port_data,
   output logic [$clog2(RATIO):0]        output_port_count,
   output logic                          output_port_last,
   output logic                          output_port_valid,
   input  logic                          output_port_ready
);

   localparam int OUT_W = IN_WIDTH * RATIO;
   localparam int IDX_W = $clog2(RATIO);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   logic [OUT_W-1:0] acc_q, acc_d;
   logic [IDX_W-1:0] acc_cnt_q, acc_cnt_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             out_last_q, out_last_d;
   logic             out_valid_q, out_valid_d;

   logic             acc_in;
   logic             completing;
   logic [OUT_W-1:0] merged;

   // Ready depends only on the output register state, never on input valid.
   assign input_port_ready = ~out_valid_q | output_port_ready;
   assign acc_in           = input_port_valid & input_port_ready;
   assign completing       = acc_in & ((acc_cnt_q == LAST_IDX) | input_port_last);

   // Accumulator with the incoming beat written into lane acc_cnt_q.
   always_comb begin
      merged = acc_q;
      for (int k = 0; k < RATIO; k++) begin
         if (acc_cnt_q == IDX_W'(k)) begin
            merged[k*IN_WIDTH +: IN_WIDTH] = input_port_data;
         end
      end
   end

   always_comb begin
      // NOTE: every variable gets a default hold value first so no path
      // through this block leaves it unassigned, which would infer a latch.
      acc_d       = acc_q;
      acc_cnt_d   = acc_cnt_q;
      out_data_d  = out_data_q;
      out_cnt_d   = out_cnt_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;

      // Drain first; a load in the same cycle overrides it below.
      if (out_valid_q && output_port_ready) begin
         out_valid_d = 1'b0;
      end

      if (completing) begin
         out_data_d  = merged;
         out_cnt_d   = CNT_W'(acc_cnt_q) + CNT_W'(1);
         out_last_d  = input_port_last;
         out_valid_d = 1'b1;
         // Clearing here keeps unwritten lanes of the next partial word zero.
         acc_d       = '0;
         acc_cnt_d   = '0;
      end else if (acc_in) begin
         acc_d       = merged;
         acc_cnt_d   = acc_cnt_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clock_port) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge inputs regardless of statement order.
      if (reset_port) begin
         acc_q       <= '0;
         acc_cnt_q   <= '0;
         out_data_q  <= '0;
         out_cnt_q   <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         acc_cnt_q   <= acc_cnt_d;
         out_data_q  <= out_data_d;
         out_cnt_q   <= out_cnt_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign output_port_data  = out_data_q;
   assign output_port_count = out_cnt_q;
   assign output_port_last  = out_last_q;
   assign output_port_valid = out_valid_q;

endmodule

// File: tb/tb_rv_width_packer.sv
// tb_rv_width_packer
// Directed stimulus for rv_width_packer (IN_WIDTH=8, RATIO=4). The stimulus
// process pushes hand-computed expected words into a queue; a monitor pops
// and compares whenever the DUT completes an output handshake.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_rv_width_packer;

   localparam int IN_WIDTH = 8;
   localparam int RATIO    = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  count;
      logic        last;
   } word_t;

   logic        clk = 1'b0;
   logic        reset_port;
   logic [7:0]  input_port_data;
   logic        input_port_last;
   logic        input_port_valid;
   logic        input_port_ready;
   logic [31:0] output_port_data;
   logic [2:0]  output_port_count;
   logic        output_port_last;
   logic        output_port_valid;
   logic        output_port_ready;

   int checks   = 0;
   int failures = 0;
   int stalls   = 0;
   word_t exp_q[$];

   always #5 clk = ~clk;

   rv_width_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
      .clock_port        (clk),
      .reset_port        (reset_port),
      .input_port_data   (input_port_data),
      .input_port_last   (input_port_last),
      .input_port_valid  (input_port_valid),
      .input_port_ready  (input_port_ready),
      .output_port_data  (output_port_data),
      .output_port_count (output_port_count),
      .output_port_last  (output_port_last),
      .output_port_valid (output_port_valid),
      .output_port_ready (output_port_ready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic send(input logic [7:0] d, input logic l);
      int n = 0;
      input_port_valid = 1'b1;
      input_port_data  = d;
      input_port_last  = l;
      @(negedge clk);
      while (!input_port_ready && n < 200) begin
         stalls++;
         n++;
         @(negedge clk);
      end
      if (n >= 200) check("send_timeout", 64'(n), 64'(0));
      next_cycle();
      input_port_valid = 1'b0;
      input_port_last  = 1'b0;
   endtask

   task automatic expect_word(input logic [31:0] d, input logic [2:0] c, input logic l);
      word_t w;
      w.data  = d;
      w.count = c;
      w.last  = l;
      exp_q.push_back(w);
   endtask

   // Scoreboard monitor: one comparison per completed output handshake.
   always @(negedge clk) begin
      if (!reset_port && output_port_valid && output_port_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(output_port_data), 64'(0));
         end else begin
            word_t w;
            w = exp_q.pop_front();
            check("out_word", 64'({output_port_data, output_port_count, output_port_last}),
                  64'({w.data, w.count, w.last}));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_port        = 1'b1;
      input_port_data   = '0;
      input_port_last   = 1'b0;
      input_port_valid  = 1'b0;
      output_port_ready = 1'b1;
      repeat (3) next_cycle();

      // Reset state
      check("rst_valid", 64'(output_port_valid), 64'(0));
      check("rst_data",  64'(output_port_data),  64'(0));
      check("rst_count", 64'(output_port_count), 64'(0));
      check("rst_last",  64'(output_port_last),  64'(0));
      check("rst_in_ready", 64'(input_port_ready), 64'(1));
      reset_port = 1'b0;
      next_cycle();

      // Full-word streaming
      stalls = 0;
      expect_word(32'h44332211, 3'd4, 1'b0);
      expect_word(32'h88776655, 3'd4, 1'b0);
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      check("stream_no_early_valid", 64'(output_port_valid), 64'(0));
      send(8'h44, 1'b0);
      check("stream_latency_valid", 64'(output_port_valid), 64'(1));
      check("stream_latency_data", 64'(output_port_data), 64'h44332211);
      send(8'h55, 1'b0);
      send(8'h66, 1'b0);
      send(8'h77, 1'b0);
      send(8'h88, 1'b0);
      check("stream_no_stalls", 64'(stalls), 64'(0));
      repeat (2) next_cycle();

      // Partial flush, then single-beat packet
      expect_word(32'h0000B2A1, 3'd2, 1'b1);
      send(8'hA1, 1'b0);
      send(8'hB2, 1'b1);
      next_cycle();
      expect_word(32'h0000005C, 3'd1, 1'b1);
      // Back-to-back single-beat packet: output full, drained and reloaded
      // on the same edge.
      expect_word(32'h0000006D, 3'd1, 1'b1);
      send(8'h5C, 1'b1);
      check("simul_first_valid", 64'(output_port_valid), 64'(1));
      send(8'h6D, 1'b1);
      check("simul_valid_held", 64'(output_port_valid), 64'(1));
      check("simul_new_data", 64'(output_port_data), 64'h0000006D);
      repeat (2) next_cycle();

      // Backpressure
      output_port_ready = 1'b0;
      expect_word(32'h04030201, 3'd4, 1'b0);
      expect_word(32'h08070605, 3'd4, 1'b0);
      fork
         begin
            for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
         end
         begin
            int n = 0;
            logic held_ok = 1'b1;
            while (!output_port_valid && n < 50) begin
               next_cycle();
               n++;
            end
            check("bp_word_present", 64'(output_port_valid), 64'(1));
            for (int i = 0; i < 5; i++) begin
               next_cycle();
               if (input_port_ready !== 1'b0 || output_port_data !== 32'h04030201 ||
                   output_port_valid !== 1'b1) held_ok = 1'b0;
            end
            check("bp_stall_and_hold", 64'(held_ok), 64'(1));
            output_port_ready = 1'b1;
         end
      join
      repeat (3) next_cycle();

      // Reset mid-packet
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      reset_port = 1'b1;
      next_cycle();
      check("midrst_valid", 64'(output_port_valid), 64'(0));
      reset_port = 1'b0;
      expect_word(32'h04030201, 3'd4, 1'b0);
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
      check("midrst_data", 64'(output_port_data), 64'h04030201);

      begin
         int n = 0;
         while (exp_q.size() != 0 && n < 100) begin
            next_cycle();
            n++;
         end
      end
      repeat (2) next_cycle();
      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      check("final_idle_valid", 64'(output_port_valid), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rv_width_packer.md
Name: rv_width_packer

Overview:
- Ready/valid width up-converter. Sits directly downstream of the forward-buffer delay line.
- Collects RATIO consecutive IN_WIDTH-bit beats into one IN_WIDTH*RATIO-bit word and emits it on a fully registered output stage.
- An input-side last flag forces early emission of a partial word with a beat count, so packet tails are never stranded.

Parameters:
- IN_WIDTH, 8, width of each input beat.
- RATIO, 4, beats per output word. Legal range is 2..16.

Ports:
- clock_port  in  1  single clock; all state updates on its rising edge.
- reset_port  in  1  synchronous, active-high reset.
- input_port_data  in  IN_WIDTH  input beat.
- input_port_last  in  1  beat is the last of its packet; qualified by valid.
- input_port_valid  in  1  input beat present.
- input_port_ready  out  1  block accepts the beat this cycle.
- output_port_data  out  IN_WIDTH*RATIO  packed word.
- output_port_count  out  $clog2(RATIO)+1  number of valid beats in the word (1..RATIO).
- output_port_last  out  1  word ends a packet.
- output_port_valid  out  1  word present.
- output_port_ready  in  1  downstream accepts the word.

Behaviour:
- Clock/reset: one clock, clock_port. reset_port is synchronous and active-high and dominates every other condition in the cycle.
- Reset values:
  - acc, acc_cnt = 0.
  - out_buf_valid = 0, so output_port_valid = 0.
  - output_port_data, output_port_count, output_port_last = 0.
- State:
  - acc: accumulator, IN_WIDTH*RATIO bits.
  - acc_cnt: 0..RATIO-1.
  - Output register: data, count, last, out_buf_valid.
- input_port_ready = ~out_buf_valid | output_port_ready.
  - Combinational. Independent of input_port_valid, input_port_data and input_port_last. No valid-to-ready paths.
  - During reset the formula still applies, but any accepted beat is discarded because reset dominates.
- Accept: acc_in = input_port_valid & input_port_ready.
- Lane placement: beat k of a word (k = acc_cnt at acceptance) goes to bits [k*IN_WIDTH +: IN_WIDTH]. The first beat is in the LSBs (little-endian).
- Completing beat: an accepted beat with acc_cnt == RATIO-1, or with input_port_last = 1. On that edge:
  - Output register loads {acc with the new lane merged}.
  - output_port_count loads acc_cnt+1.
  - output_port_last loads input_port_last.
  - out_buf_valid is set to 1.
  - acc and acc_cnt clear to 0. Lanes not written in a partial word are always 0.
- Non-completing beat: writes its lane and increments acc_cnt. Output register is unchanged.
- Output stage: if out_buf_valid & output_port_ready and no completing beat is accepted this cycle, out_buf_valid clears.
  - Simultaneous drain and load: load wins, out_buf_valid stays 1, and new contents replace the drained word.
- Latency and throughput:
  - A word is visible on the output the cycle after its completing beat is accepted.
  - Sustained input rate is 1 beat/cycle with output_port_ready held high: one word every RATIO cycles, no bubbles.
- Backpressure:
  - Output full and output_port_ready = 0: input_port_ready = 0. acc is held untouched, including a partial word.
  - Output data/count/last are stable while valid & ~ready.
- Boundaries:
  - Last on the first beat (acc_cnt = 0): word with count 1, upper lanes zero.
  - Last on beat RATIO-1: full word with count RATIO and last = 1.
  - acc_cnt never reaches RATIO; it wraps to 0 on completion.
- Reset mid-packet: the partial accumulator and any pending output word are dropped. No output is produced for them.
- The block never generates a word without a completing input beat. There is no zero-count word.

Test Plan:
- Full-word streaming: reset, output_port_ready = 1; send beats 0x11, 0x22, 0x33, 0x44, 0x55, 0x66, 0x77, 0x88 back-to-back with last = 0.
  -> 0x44332211 with count 4 appears 1 cycle after the 4th accept, then 0x88776655 with count 4. input_port_ready is 1 throughout.
- Partial flush: send 0xA1, then 0xB2 with last = 1.
  -> word 0x0000B2A1, count 2, last 1. The next word starts at lane 0.
- Single-beat packet: send 0x5C with last = 1.
  -> word 0x0000005C, count 1, last 1.
- Backpressure: hold output_port_ready = 0 after the first word is emitted; offer 0x01..0x08.
  -> input_port_ready = 0, and output data stays stable at the first word.
  -> After releasing ready, words 0x04030201 and 0x08070605 are emitted with no loss or duplication.
- Simultaneous drain and load: output_port_ready = 1 with the output full, and a completing beat accepted in the same cycle.
  -> out_buf_valid stays 1 and the new word appears the next cycle.
- Reset mid-packet: accept 0xAA and 0xBB, assert reset_port for 1 cycle, then send 0x01..0x04.
  -> output_port_valid is 0 through reset, and the first word after reset is 0x04030201, count 4. The dropped bytes never appear.
